// File: rtl/fxp_zoom_arbiter.sv
// -----------------------------------------------------------------------------
// fxp_zoom_arbiter
//   Shares one fixed-point format converter (comb_FixedPointZoom) between
//   NREQ valid/ready requesters. A round-robin arbiter picks one requester per
//   accepting cycle. Its sample is converted from WII.WIF to WOI.WOF and
//   registered together with the requester id and the overflow indications.
//   Sticky per-requester overflow flags are kept for status readback.
//
// Optional build macro: FXP_ZOOM_ARB_SATCNT_EN adds sat_cnt, which holds one
//   saturating 16-bit overflow-event counter per requester.
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   req_valid/ready  per-requester handshake (req_ready is one-hot or zero)
//   req_data         packed samples, requester i at [i*(WII+WIF) +: WII+WIF]
//   out_valid/ready  output handshake
//   out_data         converted sample (WOI+WOF bits)
//   out_id           requester that produced out_data
//   out_upflow/out_downflow  converter overflow indications for out_data
//   flag_clr         clears the sticky flags (and counters when present)
//   flag_up/flag_down sticky overflow flags per requester
//   sat_cnt          (macro only) per-requester overflow event counters
// -----------------------------------------------------------------------------

// Combinational fixed-point format converter WII.WIF -> WOI.WOF.
// Fraction first (zero-extend, or truncate with optional round-half-up), then
// the integer part (sign-extend, or narrow with saturate/wrap and overflow flags).
module comb_FixedPointZoom #(
    parameter int WII   = 8,
    parameter int WIF   = 8,
    parameter int WOI   = 8,
    parameter int WOF   = 8,
    parameter int ROOF  = 1,
    parameter int ROUND = 1
) (
    input  logic [WII+WIF-1:0] in,
    output logic [WOI+WOF-1:0] out,
    output logic               upflow,
    output logic               downflow
);
    localparam int WM = WII + WOF;   // intermediate: input integer, output fraction
    localparam int WO = WOI + WOF;

    logic [WM-1:0] mid_s;

    if (WOF == WIF) begin : g_frac_same
        assign mid_s = in;
    end else if (WOF > WIF) begin : g_frac_ext
        assign mid_s = {in, {(WOF-WIF){1'b0}}};
    end else begin : g_frac_cut
        localparam int SH = WIF - WOF;
        logic [WM-1:0] trunc_s;
        logic          rnd_s;
        assign trunc_s = in[WII+WIF-1:SH];
        // The rounding carry is dropped only at the largest positive input,
        // where it would otherwise wrap the intermediate value negative.
        if (ROUND != 0) begin : g_rnd
            assign rnd_s = in[SH-1] & (trunc_s != {1'b0, {(WM-1){1'b1}}});
        end else begin : g_nornd
            assign rnd_s = 1'b0;
        end
        assign mid_s = trunc_s + {{(WM-1){1'b0}}, rnd_s};
    end

    if (WOI >= WII) begin : g_int_ext
        if (WOI == WII) begin : g_same
            assign out = mid_s;
        end else begin : g_sext
            assign out = {{(WOI-WII){mid_s[WM-1]}}, mid_s};
        end
        assign upflow   = 1'b0;
        assign downflow = 1'b0;
    end else begin : g_int_cut
        // The value fits when every dropped integer bit equals the new sign bit.
        logic [WM-WO:0] top_s;
        logic           fits_s;
        assign top_s    = mid_s[WM-1:WO-1];
        assign fits_s   = (top_s == {(WM-WO+1){1'b0}}) | (top_s == {(WM-WO+1){1'b1}});
        assign upflow   = ~fits_s & ~mid_s[WM-1];
        assign downflow = ~fits_s &  mid_s[WM-1];
        if (ROOF != 0) begin : g_sat
            assign out = upflow   ? {1'b0, {(WO-1){1'b1}}} :
                         downflow ? {1'b1, {(WO-1){1'b0}}} : mid_s[WO-1:0];
        end else begin : g_wrap
            assign out = mid_s[WO-1:0];
        end
    end
endmodule

module fxp_zoom_arbiter #(
    parameter int NREQ  = 4,
    parameter int WII   = 8,
    parameter int WIF   = 8,
    parameter int WOI   = 8,
    parameter int WOF   = 8,
    parameter int ROOF  = 1,
    parameter int ROUND = 1,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int DW   = WII + WIF,
    localparam int WO   = WOI + WOF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WO-1:0]        out_data,
    output logic [IDW-1:0]       out_id,
    output logic                 out_upflow,
    output logic                 out_downflow,
    input  logic                 flag_clr,
    output logic [NREQ-1:0]      flag_up,
    output logic [NREQ-1:0]      flag_down
`ifdef FXP_ZOOM_ARB_SATCNT_EN
    ,
    output logic [NREQ*16-1:0]   sat_cnt
`endif
);
    typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

    state_t          state_r, state_nx_s;
    logic [IDW-1:0]  ptr_r;
    logic [WO-1:0]   out_data_r;
    logic [IDW-1:0]  out_id_r;
    logic            out_up_r, out_down_r;
    logic [NREQ-1:0] flag_up_r, flag_down_r;

    logic            load_s, found_s, xfer_s;
    logic [IDW-1:0]  gnt_id_s, ptr_nx_s;
    logic [NREQ-1:0] grant_s;
    logic [DW-1:0]   conv_in_s;
    logic [WO-1:0]   conv_out_s;
    logic            conv_up_s, conv_down_s;
    logic [IDW-1:0]  cand_s   [NREQ];
    logic [DW-1:0]   req_word_s [NREQ];

    // Search order ptr, ptr+1, ... and the unpacked request words.
    for (genvar k = 0; k < NREQ; k++) begin : g_cand
        assign cand_s[k]     = IDW'((int'(ptr_r) + k) % NREQ);
        assign req_word_s[k] = req_data[k*DW +: DW];
    end

    assign load_s = (state_r == ST_EMPTY) | out_ready;

    // Round-robin search: first valid requester starting at the pointer.
    always_comb begin
        found_s  = 1'b0;
        gnt_id_s = '0;
        for (int k = 0; k < NREQ; k++) begin
            gnt_id_s = (!found_s && req_valid[cand_s[k]]) ? cand_s[k] : gnt_id_s;
            found_s  = found_s | req_valid[cand_s[k]];
        end
    end

    // One-hot grant, suppressed when the output register cannot load or in reset.
    always_comb begin
        grant_s = '0;
        if (found_s && load_s && !rst) begin
            grant_s[gnt_id_s] = 1'b1;
        end else begin
            grant_s = '0;
        end
    end

    assign req_ready = grant_s;
    assign xfer_s    = |grant_s;
    assign conv_in_s = req_word_s[gnt_id_s];
    assign ptr_nx_s  = (gnt_id_s == IDW'(NREQ - 1)) ? '0 : gnt_id_s + IDW'(1);

    comb_FixedPointZoom #(
        .WII(WII), .WIF(WIF), .WOI(WOI), .WOF(WOF), .ROOF(ROOF), .ROUND(ROUND)
    ) u_zoom (
        .in       (conv_in_s),
        .out      (conv_out_s),
        .upflow   (conv_up_s),
        .downflow (conv_down_s)
    );

    // Output register occupancy: EMPTY/FULL next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_EMPTY: state_nx_s = xfer_s ? ST_FULL : ST_EMPTY;
            ST_FULL: begin
                if (xfer_s) begin
                    state_nx_s = ST_FULL;
                end else if (out_ready) begin
                    state_nx_s = ST_EMPTY;
                end else begin
                    state_nx_s = ST_FULL;
                end
            end
            default: state_nx_s = ST_EMPTY;
        endcase
    end

    // State register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_EMPTY;
            ptr_r   <= '0;
        end else begin
            state_r <= state_nx_s;
            if (xfer_s) begin
                ptr_r <= ptr_nx_s;
            end
        end
    end

    // Output payload register: loads only on a transfer, holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_r <= '0;
            out_id_r   <= '0;
            out_up_r   <= 1'b0;
            out_down_r <= 1'b0;
        end else if (xfer_s) begin
            out_data_r <= conv_out_s;
            out_id_r   <= gnt_id_s;
            out_up_r   <= conv_up_s;
            out_down_r <= conv_down_s;
        end
    end

    // Sticky flags: a set in the same cycle as a clear survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_up_r   <= '0;
            flag_down_r <= '0;
        end else begin
            flag_up_r   <= (flag_clr ? '0 : flag_up_r)   | (grant_s & {NREQ{conv_up_s}});
            flag_down_r <= (flag_clr ? '0 : flag_down_r) | (grant_s & {NREQ{conv_down_s}});
        end
    end

    assign out_valid    = (state_r == ST_FULL);
    assign out_data     = out_data_r;
    assign out_id       = out_id_r;
    assign out_upflow   = out_up_r;
    assign out_downflow = out_down_r;
    assign flag_up      = flag_up_r;
    assign flag_down    = flag_down_r;

`ifdef FXP_ZOOM_ARB_SATCNT_EN
    for (genvar i = 0; i < NREQ; i++) begin : g_cnt
        logic [15:0] cnt_r;
        logic        inc_s;
        assign inc_s = grant_s[i] & (conv_up_s | conv_down_s);

        // Saturating event counter; an increment beats a simultaneous clear.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_r <= 16'h0000;
            end else if (inc_s) begin
                if (flag_clr) begin
                    cnt_r <= 16'h0001;
                end else if (cnt_r != 16'hFFFF) begin
                    cnt_r <= cnt_r + 16'h0001;
                end
            end else if (flag_clr) begin
                cnt_r <= 16'h0000;
            end
        end
        assign sat_cnt[i*16 +: 16] = cnt_r;
    end
`endif
endmodule
